spi_ram_cache: RTL and testbench



---
 rtl/spi_ram_cache.sv | 171 +++++++++++++++++
 tb/tb_spi_ram_cache.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_cache.sv
// Direct-mapped write-through word cache between the CPU RAM port and the SPI RAM controller.
// Define SPI_RAM_CACHE_STATS_EN to build the saturating hit/miss counters.
module spi_ram_cache #(
   parameter int INDEX_BITS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr_in,
   input  logic [15:0] data_in,
   input  logic        start_read,
   input  logic        start_write,
   input  logic        flush,
   output logic [15:0] data_out,
   output logic        busy,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   output logic        mem_start_read,
   output logic        mem_start_write,
   input  logic [15:0] mem_data_out,
   input  logic        mem_busy,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);
   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 16 - INDEX_BITS;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD_ISSUE = 3'd1;
   localparam logic [2:0] S_RD_WAIT  = 3'd2;
   localparam logic [2:0] S_WR_ISSUE = 3'd3;
   localparam logic [2:0] S_WR_WAIT  = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [15:0]         addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [15:0]         dout_q, dout_d;
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q [ENTRIES];
   logic [15:0]         line_q [ENTRIES];

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
   logic                  req_hit;
   logic                  fill_en;
   logic [15:0]           fill_data;

   assign req_idx  = addr_in[INDEX_BITS-1:0];
   assign req_tag  = addr_in[15:INDEX_BITS];
   assign fill_idx = addr_q[INDEX_BITS-1:0];
   assign fill_tag = addr_q[15:INDEX_BITS];
   assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // NOTE: every next-state signal is defaulted first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      fill_en   = 1'b0;
      fill_data = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               valid_d = '0;
            end else if (start_write) begin
               addr_d  = addr_in;
               wdata_d = data_in;
               // Any cached word overlapping the written bytes starts at A-1, A or A+1.
               valid_d[req_idx - INDEX_BITS'(1)] = 1'b0;
               valid_d[req_idx]                  = 1'b0;
               valid_d[req_idx + INDEX_BITS'(1)] = 1'b0;
               state_d = S_WR_ISSUE;
            end else if (start_read) begin
               if (req_hit) begin
                  dout_d = line_q[req_idx];
               end else begin
                  addr_d  = addr_in;
                  state_d = S_RD_ISSUE;
               end
            end
         end
         S_RD_ISSUE: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (!mem_busy) begin
               dout_d            = mem_data_out;
               fill_en           = 1'b1;
               fill_data         = mem_data_out;
               valid_d[fill_idx] = 1'b1;
               state_d           = S_IDLE;
            end
         end
         S_WR_ISSUE: state_d = S_WR_WAIT;
         S_WR_WAIT: begin
            if (!mem_busy) begin
               fill_en           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               state_d           = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: tag/data storage is not reset; valid_q alone decides whether an entry may hit.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         line_q[fill_idx] <= fill_data;
      end
   end

   assign data_out        = dout_q;
   assign busy            = (state_q != S_IDLE);
   assign mem_addr        = (state_q != S_IDLE) ? addr_q : 16'h0000;
   assign mem_data_in     = (state_q == S_WR_ISSUE || state_q == S_WR_WAIT) ? wdata_q : 16'h0000;
   assign mem_start_read  = (state_q == S_RD_ISSUE);
   assign mem_start_write = (state_q == S_WR_ISSUE);

`ifdef SPI_RAM_CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;
   logic        rd_accept;

   // A read is accepted only when neither flush nor a write claims the idle cycle.
   assign rd_accept = (state_q == S_IDLE) && !flush && !start_write && start_read;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rd_accept && req_hit && hit_cnt_q != 16'hFFFF)
         hit_cnt_d = hit_cnt_q + 16'd1;
      if (rd_accept && !req_hit && miss_cnt_q != 16'hFFFF)
         miss_cnt_d = miss_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = 16'h0000;
   assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_ram_cache.sv
// Randomized self-checking bench for spi_ram_cache against a byte-memory / address-tracking model.
// Expected counter values follow SPI_RAM_CACHE_STATS_EN in the same way as the design build.
module tb_spi_ram_cache;
   localparam int IB = 3;
   localparam int NE = 1 << IB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr_in = '0, data_in = '0;
   logic        start_read = 1'b0, start_write = 1'b0, flush = 1'b0;
   logic [15:0] data_out, mem_addr, mem_data_in, hit_count, miss_count;
   logic        busy, mem_start_read, mem_start_write;
   logic [15:0] mem_data_out = '0;
   logic        mem_busy = 1'b0;

   spi_ram_cache #(.INDEX_BITS(IB)) dut (
      .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
      .start_read(start_read), .start_write(start_write), .flush(flush),
      .data_out(data_out), .busy(busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_start_read(mem_start_read), .mem_start_write(mem_start_write),
      .mem_data_out(mem_data_out), .mem_busy(mem_busy),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Reference: SPI RAM as bytes, and for each cache slot the word address it currently holds.
   logic [7:0]  mem [65536];
   logic        cv [NE];
   logic [15:0] ca [NE];
   logic [15:0] dout_m;
   int          hits_m, misses_m;
   int          n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int idx(input logic [15:0] a);
      return int'(a) % NE;
   endfunction

   function automatic logic [15:0] word(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   function automatic logic model_hit(input logic [15:0] a);
      return cv[idx(a)] && (ca[idx(a)] == a);
   endfunction

   function automatic logic [15:0] exp_cnt(input int c);
`ifdef SPI_RAM_CACHE_STATS_EN
      return (c > 65535) ? 16'hFFFF : 16'(c);
`else
      return (c < 0) ? 16'hFFFF : 16'h0000;
`endif
   endfunction

   function automatic logic [15:0] pick_addr();
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) return 16'($urandom_range(0, 31));
      else if (r < 85) return 16'($urandom_range(0, 3) + 65534);
      else return 16'($urandom);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NE; i++) cv[i] = 1'b0;
      dout_m   = '0;
      hits_m   = 0;
      misses_m = 0;
   endtask

   task automatic mem_wr(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] a1;
      a1      = a + 16'd1;
      mem[a]  = d[7:0];
      mem[a1] = d[15:8];
   endtask

   task automatic noise(input logic on);
      if (on) begin
         start_read  = 1'($urandom);
         start_write = 1'($urandom);
         flush       = 1'($urandom);
         addr_in     = 16'($urandom);
         data_in     = 16'($urandom);
      end else begin
         start_read  = 1'b0;
         start_write = 1'b0;
         flush       = 1'b0;
      end
   endtask

   task automatic check_idle();
      check("idle_busy", 16'(busy), 16'd0);
      check("idle_mem_rd", 16'(mem_start_read), 16'd0);
      check("idle_mem_wr", 16'(mem_start_write), 16'd0);
      check("idle_mem_addr", mem_addr, 16'd0);
      check("idle_mem_wdata", mem_data_in, 16'd0);
      check("dout_hold", data_out, dout_m);
      check("hit_count", hit_count, exp_cnt(hits_m));
      check("miss_count", miss_count, exp_cnt(misses_m));
   endtask

   // Entered at the negedge of the issue cycle; plays the controller and returns once idle.
   task automatic run_mem(input logic wr, input logic [15:0] a, input logic [15:0] d);
      int lat, n;
      check(wr ? "wr_strobe" : "rd_strobe", 16'(wr ? mem_start_write : mem_start_read), 16'd1);
      check("other_strobe", 16'(wr ? mem_start_read : mem_start_write), 16'd0);
      check("mem_addr", mem_addr, a);
      check("mem_data_in", mem_data_in, wr ? d : 16'd0);
      check("busy_issue", 16'(busy), 16'd1);
      if (wr) mem_wr(a, d);
      lat          = $urandom_range(0, 4);
      mem_busy     = (lat != 0);
      mem_data_out = (lat == 0 && !wr) ? word(a) : 16'($urandom);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         noise($urandom_range(0, 2) == 0);
         check("no_restrobe", 16'(mem_start_read | mem_start_write), 16'd0);
         check("busy_wait", 16'(busy), 16'd1);
         if (k == lat) begin
            mem_busy     = 1'b0;
            mem_data_out = wr ? 16'($urandom) : word(a);
         end
      end
      n = lat;
      do begin
         @(negedge clk);
         noise(1'b0);
         n++;
      end while (busy && n < lat + 20);
      check("latency", 16'(n), 16'(1 + ((lat > 1) ? lat : 1)));
   endtask

   task automatic do_read(input logic [15:0] a);
      logic        exp_hit;
      logic [15:0] w;
      exp_hit = model_hit(a);
      w       = word(a);
      @(negedge clk);
      addr_in    = a;
      data_in    = 16'($urandom);
      start_read = 1'b1;
      @(negedge clk);
      start_read = 1'b0;
      if (exp_hit) begin
         hits_m++;
         check("hit_busy", 16'(busy), 16'd0);
         check("hit_strobe", 16'(mem_start_read), 16'd0);
         check("hit_data", data_out, w);
      end else begin
         misses_m++;
         run_mem(1'b0, a, 16'd0);
         check("miss_data", data_out, w);
         cv[idx(a)] = 1'b1;
         ca[idx(a)] = a;
      end
      dout_m = w;
      check_idle();
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic with_rd);
      @(negedge clk);
      addr_in     = a;
      data_in     = d;
      start_write = 1'b1;
      start_read  = with_rd;
      @(negedge clk);
      start_write = 1'b0;
      start_read  = 1'b0;
      run_mem(1'b1, a, d);
      check("wr_dout", data_out, dout_m);
      for (int o = -1; o <= 1; o++) cv[idx(16'(int'(a) + o))] = 1'b0;
      cv[idx(a)] = 1'b1;
      ca[idx(a)] = a;
      check_idle();
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush       = 1'b1;
      start_read  = 1'($urandom);
      start_write = 1'($urandom);
      addr_in     = pick_addr();
      data_in     = 16'($urandom);
      @(negedge clk);
      noise(1'b0);
      check("flush_strobe", 16'(mem_start_read | mem_start_write), 16'd0);
      for (int i = 0; i < NE; i++) cv[i] = 1'b0;
      check_idle();
   endtask

   // The address given must currently miss so the design reaches RD_WAIT.
   task automatic do_reset_mid(input logic [15:0] a);
      @(negedge clk);
      addr_in    = a;
      start_read = 1'b1;
      @(negedge clk);
      start_read = 1'b0;
      check("rst_pre_strobe", 16'(mem_start_read), 16'd1);
      mem_busy = 1'b1;
      @(negedge clk);
      check("rst_pre_busy", 16'(busy), 16'd1);
      rst = 1'b1;
      #1;
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_dout", data_out, 16'd0);
      check("rst_mem_rd", 16'(mem_start_read), 16'd0);
      check("rst_mem_addr", mem_addr, 16'd0);
      check("rst_hits", hit_count, 16'd0);
      check("rst_misses", miss_count, 16'd0);
      mem_busy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_busy", 16'(busy), 16'd0);
      check("reset_dout", data_out, 16'd0);
      check("reset_mem_rd", 16'(mem_start_read), 16'd0);
      check("reset_mem_wr", 16'(mem_start_write), 16'd0);
      check("reset_hits", hit_count, 16'd0);
      check("reset_misses", miss_count, 16'd0);
      rst = 1'b0;

      mem[16'h0010] = 8'hEF;
      mem[16'h0011] = 8'hBE;
      do_read(16'h0010);
      check("cold_beef", data_out, 16'hBEEF);
      do_read(16'h0010);
      check("warm_beef", data_out, 16'hBEEF);

      do_read(16'h0018);
      do_read(16'h0010);

      do_read(16'h0020);
      do_read(16'h0021);
      do_write(16'h0021, 16'h1234, 1'b0);
      do_read(16'h0021);
      check("wr_then_hit", data_out, 16'h1234);
      do_read(16'h0020);

      do_write(16'h0030, 16'h5555, 1'b1);

      do_read(16'h0010);
      do_flush();
      do_read(16'h0010);

      do_read(16'hFFFF);
      do_write(16'h0000, 16'hA5C3, 1'b0);
      do_read(16'hFFFF);

      do_flush();
      do_reset_mid(16'h0010);
      do_read(16'h0010);
      check("stats_miss1", miss_count, exp_cnt(1));
      do_read(16'h0010);
      do_read(16'h0010);
      do_read(16'h0010);
      do_read(16'h0018);
      check("stats_hits", hit_count, exp_cnt(3));
      check("stats_misses", miss_count, exp_cnt(2));

      for (int t = 0; t < 300; t++) begin
         int op;
         op = $urandom_range(0, 99);
         if (op < 55) do_read(pick_addr());
         else if (op < 80) do_write(pick_addr(), 16'($urandom), 1'b0);
         else if (op < 90) do_write(pick_addr(), 16'($urandom), 1'b1);
         else do_flush();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
